williams2_rom_loader: RTL

- Sequences the HPS ROM download stream (ioctl_*) into the williams2 ROM write port (dn_addr/dn_data/dn_wr).
- Holds the game core in reset from power-up and during every download, then releases it after a settle delay.
- Buffers bytes in a 2-entry FIFO so a write port with back-pressure (dn_ready) can be used.
- Reports a completion flag and an error flag for the last load.

---
 rtl/williams2_loader_pkg.sv | 36 +++
 rtl/williams2_loader_fifo.sv | 42 ++++
 rtl/williams2_rom_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/williams2_loader_pkg.sv
// Shared types for the williams2 ROM loader: FSM states, FIFO entry layout
// and ROM region indices used to build the one-hot region select.
package williams2_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } loader_state_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  localparam logic [1:0] REGION_CPU  = 2'd0;
  localparam logic [1:0] REGION_SND  = 2'd1;
  localparam logic [1:0] REGION_GFX  = 2'd2;
  localparam logic [1:0] REGION_PROM = 2'd3;

  function automatic logic [3:0] region_sel(input logic [1:0] region);
    logic [3:0] sel;
    sel = 4'b0000;
    case (region)
      REGION_CPU:  sel = 4'b0001;
      REGION_SND:  sel = 4'b0010;
      REGION_GFX:  sel = 4'b0100;
      REGION_PROM: sel = 4'b1000;
      default:     sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/williams2_loader_fifo.sv
// Two-entry synchronous FIFO between the HPS byte stream and the ROM write port.
// The caller gates push/pop; a push while full is only legal with a pop in the same cycle.
module williams2_loader_fifo
  import williams2_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  fifo_entry_t mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/williams2_rom_loader.sv
// Streams the HPS ROM download into the williams2 ROM write port and sequences core reset.
// Build option ROM_CHECKSUM_EN adds the rom_sum output and the EXP_SUM check.
module williams2_rom_loader
  import williams2_loader_pkg::*;
#(
  parameter logic [15:0] ROM_INDEX = 16'd0,
  parameter logic [17:0] ROM_SIZE  = 18'h2C000,
  parameter int unsigned REL_DELAY = 1024,
  parameter int unsigned CNT_W     = 19
`ifdef ROM_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM   = 16'h0000
`endif
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] ioctl_index,
  output logic [17:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic [3:0]  dn_sel,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0] rom_sum
`endif
);

  // state  | meaning
  // IDLE   | power-up, core held in reset, waiting for a matching download
  // LOAD   | accepting ioctl bytes into the FIFO
  // DRAIN  | download ended, flushing FIFO to the write port
  // HOLD   | settle delay before core release
  // RUN    | core running, load result latched

  localparam int unsigned HOLD_W = (REL_DELAY > 1) ? $clog2(REL_DELAY) : 1;

  loader_state_t     state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              overrun;
  logic              overflow;
  logic              sum_bad;

  fifo_entry_t       head;
  fifo_entry_t       push_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dl_match;
  logic              in_range;
  logic              wr_load;
  logic              push;
  logic              pop;

  assign dl_match  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign in_range  = (ioctl_addr < {7'd0, ROM_SIZE});
  assign wr_load   = (state == ST_LOAD) && ioctl_wr;
  assign pop       = !fifo_empty && dn_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push      = wr_load && in_range && (!fifo_full || pop);
  assign push_data = '{addr: ioctl_addr[17:0], data: ioctl_dout};

  williams2_loader_fifo u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dn_wr   = !fifo_empty;
  assign dn_addr = head.addr;
  assign dn_data = head.data;
  assign dn_sel  = dn_wr ? region_sel(head.addr[17:16]) : 4'b0000;

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 16'h0000;
    end else if (((state == ST_IDLE) || (state == ST_RUN)) && dl_match) begin
      sum_q <= 16'h0000;
    end else if (pop) begin
      sum_q <= sum_q + {8'h00, head.data};
    end
  end

  assign rom_sum = sum_q;
  assign sum_bad = (EXP_SUM != 16'h0000) && (sum_q != EXP_SUM);
`else
  assign sum_bad = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      hold_cnt   <= '0;
      overrun    <= 1'b0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      if (push && (byte_cnt != '1)) byte_cnt <= byte_cnt + 1'b1;
      if (wr_load && !in_range) overflow <= 1'b1;
      if (wr_load && in_range && fifo_full && !pop) overrun <= 1'b1;

      case (state)
        ST_IDLE, ST_RUN: begin
          if (dl_match) begin
            state      <= ST_LOAD;
            byte_cnt   <= '0;
            overrun    <= 1'b0;
            overflow   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!ioctl_download) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_W'(REL_DELAY - 1);
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            load_done  <= 1'b1;
            load_err   <= overrun || overflow || sum_bad ||
                          (byte_cnt != CNT_W'(ROM_SIZE));
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
